// File: rtl/dff_sync_reset.sv
// Parameterised D register with write enable, synchronous active-high reset and a written-data flag.
// Optional registered even-parity output q_par when DFF_PARITY_EN is defined.
module dff_sync_reset #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
`ifdef DFF_PARITY_EN
  ,
  output logic             q_par
`endif
);

  // Reset outranks write; with neither, everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RESET_VALUE;
      q_vld <= 1'b0;
    end else if (wr_en) begin
      q     <= d;
      q_vld <= 1'b1;
    end
  end

`ifdef DFF_PARITY_EN
  // Parity is computed from the incoming value so it lands on the same edge as q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_par <= ^RESET_VALUE;
    end else if (wr_en) begin
      q_par <= ^d;
    end
  end
`endif

endmodule

// File: tb/tb_dff_sync_reset.sv
// Randomised self-checking bench for dff_sync_reset against a last-written-value reference model.
// Define DFF_PARITY_EN to also check q_par.
module tb_dff_sync_reset;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'h00;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_vld;
`ifdef DFF_PARITY_EN
  logic             q_par;
`endif

  dff_sync_reset #(.WIDTH(WIDTH), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .d     (d),
    .q     (q),
    .q_vld (q_vld)
`ifdef DFF_PARITY_EN
    ,
    .q_par (q_par)
`endif
  );

  // Clock / reset: 40 ns period, reset asserted from time zero.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the last value written since reset, and whether one exists.
  logic [WIDTH-1:0] last_written;
  logic             written_since_rst;
  logic             model_known = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_q();
    return written_since_rst ? last_written : RV;
  endfunction

  task automatic compare_outputs(input string tag);
    logic [WIDTH-1:0] e;
    e = exp_q.pop_front();
    if (model_known) begin
      check({tag, ".q"}, 32'(q), 32'(e));
      check({tag, ".q_vld"}, 32'(q_vld), 32'(written_since_rst));
`ifdef DFF_PARITY_EN
      check({tag, ".q_par"}, 32'(q_par), 32'(^e));
`endif
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, sample 10 ns later.
  task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] dv, input string tag);
    @(negedge clk);
    rst   = r;
    wr_en = w;
    d     = dv;
    @(posedge clk);
    if (r) begin
      written_since_rst = 1'b0;
      model_known       = 1'b1;
    end else if (w) begin
      last_written      = dv;
      written_since_rst = 1'b1;
    end
    exp_q.push_back(model_q());
    #10;
    compare_outputs(tag);
  endtask

  // A reset glitch that is gone again before the rising edge must not disturb anything.
  task automatic rst_glitch(input string tag);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    d     = WIDTH'($urandom);
    #5 rst = 1'b1;
    #5 rst = 1'b0;
    @(posedge clk);
    exp_q.push_back(model_q());
    #10;
    compare_outputs(tag);
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    d     = '0;
    last_written      = '0;
    written_since_rst = 1'b0;

    // Reset with a write attempted: write is ignored.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 8'hA5, "reset");
    check("reset_vld_low", 32'(q_vld), 32'd0);

    step(1'b0, 1'b1, 8'h3C, "write");
    check("write_val", 32'(q), 32'h3C);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, WIDTH'($urandom), "hold");
    check("hold_val", 32'(q), 32'h3C);

    for (int i = 0; i < 100; i++)
      step(1'b0, ((i / 5) % 2) == 0, WIDTH'($urandom), "toggle");

    rst_glitch("glitch");

    // Reset mid-operation with a simultaneous write, then held.
    step(1'b0, 1'b1, 8'hFF, "pre_rst");
    step(1'b1, 1'b1, 8'h12, "rst_prio");
    check("rst_prio_val", 32'(q), 32'h00);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'($urandom_range(0, 1)), WIDTH'($urandom), "rst_hold");

    // Writing the reset value still marks the register as written.
    step(1'b0, 1'b1, RV, "write_rv");
    check("write_rv_vld", 32'(q_vld), 32'd1);

`ifdef DFF_PARITY_EN
    step(1'b0, 1'b1, 8'h07, "par07");
    check("par07_bit", 32'(q_par), 32'd1);
    step(1'b0, 1'b1, 8'h03, "par03");
    check("par03_bit", 32'(q_par), 32'd0);
    step(1'b1, 1'b0, 8'h00, "par_rst");
    check("par_rst_bit", 32'(q_par), 32'd0);
`endif

    // Random soak with occasional resets.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), WIDTH'($urandom), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
